// File: rtl/pkt_inject_if.sv
// pkt_inject_if: the flit path through the injector.
//   Source side : src_data/src_valid in, src_ready out.
//   FIFO side   : ordy (room for a whole packet) and full in; odata/wr_en out
//                 to the downstream FIFO's idata/wr_en write port.
// master = the injector, slave = whatever drives the source and models the FIFO.
interface pkt_inject_if #(
  parameter int DATAW = 31
);
  logic [DATAW:0] src_data;
  logic           src_valid;
  logic           src_ready;
  logic           ordy;
  logic           full;
  logic [DATAW:0] odata;
  logic           wr_en;

  modport master (
    input  src_data, src_valid, ordy, full,
    output src_ready, odata, wr_en
  );

  modport slave (
    output src_data, src_valid, ordy, full,
    input  src_ready, odata, wr_en
  );
endinterface

// File: rtl/pkt_inject.sv
// pkt_inject: write-side master for a router input FIFO.
// Moves flits from a local source into the downstream FIFO. A packet
// (PKTLEN+1 flits) only starts when ordy says the FIFO can hold all of it;
// once started it runs to completion without looking at ordy again.
// Ports:
//   clk, rst_      clock (rising edge), synchronous active-low reset
//   bus (master)   src_data/src_valid/src_ready, ordy/full, odata/wr_en
//   busy           packet in progress (SEND or GAP)
//   pkt_cnt        packets fully sent, wrapping counter
//   err            sticky: a write was issued while full was high
module pkt_inject #(
  parameter int DATAW  = 31,
  parameter int PKTLEN = 3,
  parameter int CNTW   = 15
) (
  input  logic           clk,
  input  logic           rst_,
  pkt_inject_if.master   bus,
  output logic           busy,
  output logic [CNTW:0]  pkt_cnt,
  output logic           err
);

  // Smallest counter that can hold the index of the last flit.
  localparam int FCW = (PKTLEN < 1) ? 1 : $clog2(PKTLEN + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state, state_nxt;
  logic [FCW-1:0] fcnt, fcnt_nxt;
  logic           accept;
  logic           last;
  logic           wr_q;
  logic [DATAW:0] odata_q;

  always_comb begin
    state_nxt     = state;
    fcnt_nxt      = fcnt;
    bus.src_ready = 1'b0;
    accept        = 1'b0;
    last          = 1'b0;
    case (state)
      // The start decision needs a flit waiting; ordy alone starts nothing.
      IDLE: if (bus.src_valid && bus.ordy) state_nxt = SEND;
      SEND: begin
        bus.src_ready = 1'b1;
        accept        = bus.src_valid;
        if (accept) begin
          if (fcnt == FCW'(PKTLEN)) begin
            last      = 1'b1;
            fcnt_nxt  = '0;
            state_nxt = GAP;
          end else begin
            fcnt_nxt = fcnt + FCW'(1);
          end
        end
      end
      // One dead cycle so ordy reflects the final write before the next start.
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state   <= IDLE;
      fcnt    <= '0;
      wr_q    <= 1'b0;
      odata_q <= '0;
      pkt_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      wr_q  <= accept;
      if (accept) odata_q <= bus.src_data;
      // Bumped on the accept of the last flit so it shows up together with
      // that flit's write strobe.
      if (last) pkt_cnt <= pkt_cnt + 1'b1;
      if (wr_q && bus.full) err <= 1'b1;
    end
  end

  assign bus.wr_en = wr_q;
  assign bus.odata = odata_q;
  assign busy      = (state != IDLE);

endmodule
